// File: rtl/adder_scheduler_pkg.sv
// rtl/adder_scheduler_pkg.sv - shared constants and types for the adder scheduler
//
// Purpose: default geometry of the scheduler, the requester-ID width, the
// response FIFO entry layout and the credit counter type. The top module
// takes its parameter defaults from here, so the struct and credit widths
// below always match a default-parameter instance.
package adder_scheduler_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int LATENCY_DEF = 2;
    localparam int DEPTH_DEF   = 4;

    localparam int ID_W = $clog2(N_REQ_DEF);

    // Wide enough to hold the value DEPTH itself (all credits consumed).
    typedef logic [$clog2(DEPTH_DEF+1)-1:0] credit_t;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [WIDTH_DEF-1:0] sum;
        logic                 overflow;
    } rsp_entry_t;

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// rtl/adder_scheduler_rr_arbiter.sv - round-robin arbiter with one-hot grant
//
// Purpose: picks the first requester at or after (last+1) mod N that is
// requesting. The last-grant pointer moves only when the caller reports a
// completed transfer via advance.
// Ports:
//   clk, rst     clock, synchronous active-high reset (pointer -> N-1)
//   req          per-requester request
//   enable       when low no grant is given
//   advance      a transfer happened this cycle on the current grant
//   grant        one-hot grant (combinational)
//   grant_idx    binary index of the granted requester
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        // Scan N positions starting just after the last winner; the last
        // position examined is the previous winner itself.
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && enable && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(N - 1);
        end else if (advance) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// rtl/adder_scheduler.sv - round-robin sharing of one fixed-latency adder
//
// Purpose: arbitrates N_REQ operand requesters onto a single external adder,
// one issue per cycle, carries the requester ID alongside the adder pipeline
// and returns results in issue order through a credit-protected FIFO.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              per-requester handshake (ready = grant)
//   req_a/req_b                      packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_valid/add_a/add_b            registered issue to the adder
//   add_sum/add_overflow             adder result, LATENCY cycles after add_valid
//   rsp_valid/rsp_ready              response handshake at the FIFO head
//   rsp_id/rsp_sum/rsp_overflow      response payload
//   ovf_sticky                       any returned response had overflow
//   busy                             operations accepted but not yet returned
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     add_valid,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_overflow,
    output logic                     ovf_sticky,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- arbitration and credits ----------------
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    credit_t          credits;
    logic             can_grant;
    logic             transfer;
    logic             pop;

    // Registered count only: a pop at full frees its credit one cycle later.
    assign can_grant = credits < credit_t'(DEPTH);
    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .enable    (can_grant),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({transfer, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    assign busy = (credits != '0);

    // ---------------- issue and ID pipeline ----------------
    logic [IDW-1:0] id_pipe  [LATENCY+1];
    logic [LATENCY:0] vld_pipe;
    logic           capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            add_valid <= transfer;
            if (transfer) begin
                add_a <= req_a[grant_idx*WIDTH +: WIDTH];
                add_b <= req_b[grant_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 0 lines up with add_valid; stage LATENCY lines up with add_sum.
    // Clearing the valid bits on reset is what makes late adder outputs harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k <= LATENCY; k++) id_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= transfer;
            id_pipe[0]  <= grant_idx;
            for (int k = 1; k <= LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                id_pipe[k]  <= id_pipe[k-1];
            end
        end
    end

    assign capture = vld_pipe[LATENCY];

    // ---------------- response FIFO ----------------
    rsp_entry_t     mem [DEPTH];
    rsp_entry_t     head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    credit_t        fill;

    assign rsp_valid = (fill != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Credits bound occupancy to DEPTH, so capture never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= '{id: id_pipe[LATENCY], sum: add_sum, overflow: add_overflow};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (capture) wr_ptr <= next_ptr(wr_ptr);
            if (pop)     rd_ptr <= next_ptr(rd_ptr);
            case ({capture, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    assign head         = mem[rd_ptr];
    assign rsp_id       = head.id;
    assign rsp_sum      = head.sum;
    assign rsp_overflow = head.overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (pop && rsp_overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_scheduler.sv
// tb/tb_adder_scheduler.sv - directed self-checking bench for adder_scheduler
module tb_adder_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        add_valid;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_overflow;
    logic        ovf_sticky;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    adder_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .add_valid    (add_valid),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum),
        .add_overflow (add_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_overflow (rsp_overflow),
        .ovf_sticky   (ovf_sticky),
        .busy         (busy)
    );

    // External two-cycle adder model.
    logic [8:0] p1, p2;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b};
        p2 <= p1;
    end
    assign add_sum      = p2[7:0];
    assign add_overflow = p2[8];

    // Default operands: requester i adds a={11,22,33,44}[i] and b=i+1.
    logic [7:0] exp_sum [4] = '{8'h12, 8'h24, 8'h36, 8'h48};
    int         exp_q [$];

    int         t_ids  [13];
    logic [3:0] t_rv   [13];
    logic       t_rr   [13];
    logic       t_rspv [13];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        req_a = {8'h44, 8'h33, 8'h22, 8'h11};
        req_b = {8'h04, 8'h03, 8'h02, 8'h01};
    endtask

    // Compare the FIFO head against the oldest expected response.
    task automatic check_rsp();
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                chk("rsp_id", 32'(rsp_id), 32'(exp_q[0]));
                chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum[exp_q[0]]));
                chk("rsp_ovf", 32'(rsp_overflow), 32'd0);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic run_table(input int n);
        for (int k = 0; k < n; k++) begin
            req_valid = t_rv[k];
            rsp_ready = t_rr[k];
            #1;
            chk($sformatf("grant_c%0d", k), 32'(req_ready),
                (t_ids[k] < 0) ? 32'd0 : (32'd1 << t_ids[k]));
            chk($sformatf("rspv_c%0d", k), 32'(rsp_valid), 32'(t_rspv[k]));
            if (t_ids[k] >= 0) exp_q.push_back(t_ids[k]);
            check_rsp();
            step();
        end
        req_valid = 4'b0000;
    endtask

    task automatic drain();
        logic done;
        done      = 1'b0;
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 30 && !done; i++) begin
            check_rsp();
            if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
            else step();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_valid", 32'(add_valid), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_ops();
        do_reset();

        // 1: single op from req0, four-cycle round trip.
        req_a[7:0] = 8'h12;
        req_b[7:0] = 8'h34;
        req_valid  = 4'b0001;
        rsp_ready  = 1'b1;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        chk("t1_add_valid", 32'(add_valid), 32'd1);
        chk("t1_add_a", 32'(add_a), 32'h12);
        chk("t1_add_b", 32'(add_b), 32'h34);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("t1_rspv_early", 32'(rsp_valid), 32'd0);
        step();
        chk("t1_rspv", 32'(rsp_valid), 32'd1);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_sum", 32'(rsp_sum), 32'h46);
        chk("t1_ovf", 32'(rsp_overflow), 32'd0);
        step();
        chk("t1_rspv_after", 32'(rsp_valid), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        set_ops();

        // 2: req2 FF+01 overflows; sticky flag latches.
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'h01;
        req_valid    = 4'b0100;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        chk("t2_rspv", 32'(rsp_valid), 32'd1);
        chk("t2_id", 32'(rsp_id), 32'd2);
        chk("t2_sum", 32'(rsp_sum), 32'h00);
        chk("t2_ovf", 32'(rsp_overflow), 32'd1);
        step();
        chk("t2_sticky", 32'(ovf_sticky), 32'd1);
        repeat (4) step();
        chk("t2_sticky_hold", 32'(ovf_sticky), 32'd1);
        set_ops();
        do_reset();

        // 3: all requesters valid, consumer always ready. Five-cycle round
        // trip with four credits gives four grants then one stall.
        t_ids  = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1, 0, 1, -1};
        t_rspv = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        for (int k = 0; k < 13; k++) begin
            t_rv[k] = 4'b1111;
            t_rr[k] = 1'b1;
        end
        run_table(12);
        drain();

        // 4: consumer stalled: four accepts then no grant; release drains in
        // order, with one bubble after the first pop.
        t_ids  = '{2, 3, 0, 1, -1, -1, -1, -1, -1, 2, 3, 0, 1};
        t_rspv = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 13; k++) begin
            t_rv[k] = 4'b1111;
            t_rr[k] = (k >= 8);
        end
        run_table(13);
        drain();

        // 5: only req1 valid, then req3 joins and is served next.
        t_ids  = '{1, 1, 1, 1, -1, 1, 3, 1, -1, -1, -1, -1, -1};
        t_rspv = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        t_rv   = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                   4'b1010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 13; k++) t_rr[k] = 1'b1;
        run_table(8);
        drain();

        // 6: reset with three operations in flight.
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        #1;
        chk("t6_grant0", 32'(req_ready), 32'h4);
        step();
        chk("t6_grant1", 32'(req_ready), 32'h1);
        step();
        chk("t6_grant2", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        rst       = 1'b1;
        #1;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        chk("t6_rspv_post", 32'(rsp_valid), 32'd0);
        chk("t6_busy_post", 32'(busy), 32'd0);
        chk("t6_add_valid", 32'(add_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t6_stale_%0d", i), 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("t6_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        exp_q.push_back(0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
